// File: rtl/drop_timer_if.sv
// Control/status bundle between the gravity drop timer and the game-logic FSM.
// The game logic drives the master side and the drop timer sits on the slave side.
interface drop_timer_if #(
   parameter int SPEED_W = 64
);
   logic               enable;
   logic               pause;
   logic               restart;
   logic [SPEED_W-1:0] move_speed;
   logic               soft_drop;
   logic               tick_ack;
   logic               drop_req;
   logic               busy;
   logic [15:0]        drop_count;

   modport master (
      output enable, pause, restart, move_speed, soft_drop, tick_ack,
      input  drop_req, busy, drop_count
   );

   modport slave (
      input  enable, pause, restart, move_speed, soft_drop, tick_ack,
      output drop_req, busy, drop_count
   );
endinterface

// File: rtl/drop_timer.sv
// Gravity drop timer: counts move_speed cycles, holds drop_req until acknowledged.
// Define DROP_TIMER_STATS_EN to build the saturating acknowledged-drop counter.
module drop_timer #(
   parameter int SPEED_W    = 64,
   parameter int SOFT_SHIFT = 3,
   parameter int MIN_PERIOD = 4
) (
   input  logic        clk,
   input  logic        rst,
   drop_timer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   localparam logic [SPEED_W-1:0] MIN_P = SPEED_W'(MIN_PERIOD);
   localparam logic [SPEED_W-1:0] ONE   = SPEED_W'(1);

   state_t             state_reg, state_next;
   logic [SPEED_W-1:0] cnt_reg, cnt_next;
   logic [SPEED_W-1:0] period_reg, period_next;
   logic               drop_req_reg, drop_req_next;
   logic               busy_reg, busy_next;
   logic               soft_reg;
   logic [SPEED_W-1:0] base_period, eff_period, term_period;
   logic               soft_rise;

   // Period that would be latched at this cycle's latch point, clamped to the floor.
   always_comb begin
      base_period = bus.soft_drop ? (bus.move_speed >> SOFT_SHIFT) : bus.move_speed;
      eff_period  = (base_period < MIN_P) ? MIN_P : base_period;
   end

   assign soft_rise = bus.soft_drop & ~soft_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         period_reg   <= MIN_P;
         drop_req_reg <= 1'b0;
         busy_reg     <= 1'b0;
         soft_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         period_reg   <= period_next;
         drop_req_reg <= drop_req_next;
         busy_reg     <= busy_next;
         soft_reg     <= bus.soft_drop;
      end
   end

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      period_next   = period_reg;
      drop_req_next = drop_req_reg;
      // A soft-drop rise compares against the freshly shortened period on the same edge.
      term_period   = soft_rise ? eff_period : period_reg;

      if (bus.restart) begin
         cnt_next      = '0;
         drop_req_next = 1'b0;
         if (bus.enable) begin
            state_next  = RUN;
            period_next = eff_period;
         end else begin
            state_next  = IDLE;
         end
      end else if (!bus.enable) begin
         state_next    = IDLE;
         cnt_next      = '0;
         drop_req_next = 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               state_next  = RUN;
               period_next = eff_period;
               cnt_next    = '0;
            end
            RUN: begin
               if (soft_rise) begin
                  period_next = eff_period;
               end
               // >= rather than == so a period shortened while paused cannot let cnt run away.
               if (!bus.pause) begin
                  if (cnt_reg >= term_period - ONE) begin
                     cnt_next      = '0;
                     drop_req_next = 1'b1;
                     state_next    = WAIT_ACK;
                  end else begin
                     cnt_next = cnt_reg + ONE;
                  end
               end
            end
            WAIT_ACK: begin
               if (bus.tick_ack) begin
                  drop_req_next = 1'b0;
                  period_next   = eff_period;
                  state_next    = RUN;
               end
            end
            default: begin
               state_next    = IDLE;
               cnt_next      = '0;
               drop_req_next = 1'b0;
            end
         endcase
      end

      busy_next = (state_next == RUN) || (state_next == WAIT_ACK);
   end

   assign bus.drop_req = drop_req_reg;
   assign bus.busy     = busy_reg;

`ifdef DROP_TIMER_STATS_EN
   logic        ack_accept;
   logic [15:0] count_reg;

   assign ack_accept = (state_reg == WAIT_ACK) && bus.enable && !bus.restart && bus.tick_ack;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg <= 16'h0000;
      end else if (bus.restart) begin
         count_reg <= 16'h0000;
      end else if (ack_accept && (count_reg != 16'hFFFF)) begin
         count_reg <= count_reg + 16'd1;
      end
   end

   assign bus.drop_count = count_reg;
`else
   assign bus.drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_drop_timer.sv
// Randomized and directed checks of drop_timer against an interval-level reference model.
module tb_drop_timer;
`ifdef DROP_TIMER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   drop_timer_if #(.SPEED_W(64)) tb_if ();

   drop_timer #(
      .SPEED_W    (64),
      .SOFT_SHIFT (3),
      .MIN_PERIOD (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (tb_if.slave)
   );

   // Reference model: phase 0 idle, 1 counting, 2 request outstanding; tk = elapsed ticks.
   typedef struct packed {
      logic [1:0]  ph;
      logic [63:0] tk;
      logic [63:0] pr;
      logic        rq;
      logic [15:0] dc;
      logic        sp;
   } mstate_t;

   mstate_t m;

   function automatic logic [63:0] eff(logic [63:0] ms, logic sd);
      logic [63:0] b;
      b = sd ? (ms / 64'd8) : ms;
      return (b < 64'd4) ? 64'd4 : b;
   endfunction

   function automatic mstate_t step(mstate_t s, logic en, logic pa, logic rs,
                                    logic [63:0] ms, logic sd, logic ak);
      mstate_t     n;
      logic [63:0] e;
      n    = s;
      e    = eff(ms, sd);
      n.sp = sd;
      if (rs) begin
         n.dc = 16'd0;
         n.rq = 1'b0;
         n.tk = 64'd0;
         n.ph = en ? 2'd1 : 2'd0;
         if (en) n.pr = e;
      end else if (!en) begin
         n.ph = 2'd0;
         n.rq = 1'b0;
         n.tk = 64'd0;
      end else if (s.ph == 2'd0) begin
         n.ph = 2'd1;
         n.pr = e;
         n.tk = 64'd0;
      end else if (s.ph == 2'd1) begin
         if (sd && !s.sp) n.pr = e;
         if (!pa) begin
            if (s.tk + 64'd1 >= n.pr) begin
               n.ph = 2'd2;
               n.rq = 1'b1;
               n.tk = 64'd0;
            end else begin
               n.tk = s.tk + 64'd1;
            end
         end
      end else if (ak) begin
         n.ph = 2'd1;
         n.rq = 1'b0;
         n.pr = e;
         if (s.dc != 16'hFFFF) n.dc = s.dc + 16'd1;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m <= '{ph: 2'd0, tk: 64'd0, pr: 64'd4, rq: 1'b0, dc: 16'd0, sp: 1'b0};
      end else begin
         m <= step(m, tb_if.enable, tb_if.pause, tb_if.restart,
                   tb_if.move_speed, tb_if.soft_drop, tb_if.tick_ack);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("cyc_drop_req", {63'd0, tb_if.drop_req}, {63'd0, m.rq});
         chk("cyc_busy", {63'd0, tb_if.busy}, {63'd0, (m.ph != 2'd0)});
         chk("cyc_drop_count", {48'd0, tb_if.drop_count}, STATS ? {48'd0, m.dc} : 64'd0);
      end
   end

   // kick: 0 enable only, 1 restart, 2 tick_ack, 3 restart+tick_ack on the first edge.
   // n counts edges from the kick edge up to and including the edge that raises drop_req.
   task automatic run_interval(input int kick, input logic [63:0] ms, input int soft_at,
                               input int pa, input int plen, output int n);
      tb_if.move_speed = ms;
      tb_if.enable     = 1'b1;
      tb_if.pause      = 1'b0;
      tb_if.soft_drop  = (soft_at == 1);
      tb_if.restart    = (kick == 1) || (kick == 3);
      tb_if.tick_ack   = (kick == 2) || (kick == 3);
      n = 0;
      while (n < 300) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         tb_if.restart   = 1'b0;
         tb_if.tick_ack  = 1'b0;
         tb_if.pause     = (n + 1 >= pa) && (n + 1 < pa + plen);
         tb_if.soft_drop = (soft_at > 0) && (n + 1 >= soft_at);
         if (tb_if.drop_req) break;
      end
      tb_if.pause = 1'b0;
      $display("interval kick=%0d ms=%0d soft_at=%0d pause=%0d/%0d -> %0d edges",
               kick, ms, soft_at, pa, plen, n);
   endtask

   logic [63:0] speeds [8] = '{64'd0, 64'd2, 64'd4, 64'd5, 64'd10, 64'd16, 64'd33, 64'd80};

   initial begin
      int n;
      tb_if.enable     = 1'b0;
      tb_if.pause      = 1'b0;
      tb_if.restart    = 1'b0;
      tb_if.move_speed = 64'd10;
      tb_if.soft_drop  = 1'b0;
      tb_if.tick_ack   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_drop_req", {63'd0, tb_if.drop_req}, 64'd0);
      chk("reset_busy", {63'd0, tb_if.busy}, 64'd0);
      chk("reset_drop_count", {48'd0, tb_if.drop_count}, 64'd0);

      // Entry edge plus a 10-cycle period.
      run_interval(0, 64'd10, 0, 0, 0, n);
      chk("base_interval", n, 64'd11);

      repeat (50) @(negedge clk);
      chk("held_50", {63'd0, tb_if.drop_req}, 64'd1);
      tb_if.pause = 1'b1;
      repeat (5) @(negedge clk);
      tb_if.pause = 1'b0;
      chk("held_paused", {63'd0, tb_if.drop_req}, 64'd1);

      run_interval(2, 64'd10, 0, 0, 0, n);
      chk("ack_interval", n, 64'd11);
      chk("count_after_ack", {48'd0, tb_if.drop_count}, STATS ? 64'd1 : 64'd0);

      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      $display("async reset asserted at %0t", $time);
      chk("async_drop_req", {63'd0, tb_if.drop_req}, 64'd0);
      chk("async_busy", {63'd0, tb_if.busy}, 64'd0);
      chk("async_drop_count", {48'd0, tb_if.drop_count}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      run_interval(0, 64'd10, 0, 0, 0, n);
      chk("post_reset_interval", n, 64'd11);
      run_interval(3, 64'd10, 0, 0, 0, n);
      chk("restart_ack_interval", n, 64'd11);
      chk("restart_ack_count", {48'd0, tb_if.drop_count}, 64'd0);

      run_interval(1, 64'd0, 0, 0, 0, n);
      chk("clamp_ms0", n, 64'd5);
      run_interval(1, 64'd2, 0, 0, 0, n);
      chk("clamp_ms2", n, 64'd5);
      run_interval(1, 64'd16, 1, 0, 0, n);
      chk("clamp_soft16", n, 64'd5);

      // Rise seen at cnt=3: period becomes 80>>3=10, fires when cnt reaches 9.
      run_interval(1, 64'd80, 5, 0, 0, n);
      chk("soft_rise_cnt3", n, 64'd11);
      // Rise seen at cnt=40 is already past the new terminal: fires on that edge.
      run_interval(1, 64'd80, 42, 0, 0, n);
      chk("soft_rise_cnt40", n, 64'd42);

      run_interval(1, 64'd10, 0, 5, 7, n);
      chk("pause_7", n, 64'd18);

      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         tb_if.enable   = ($urandom_range(0, 99) < 97);
         tb_if.pause    = ($urandom_range(0, 99) < 8);
         tb_if.restart  = ($urandom_range(0, 99) < 2);
         tb_if.tick_ack = ($urandom_range(0, 99) < 35);
         if ($urandom_range(0, 99) < 5) tb_if.soft_drop = ~tb_if.soft_drop;
         if ($urandom_range(0, 99) < 10) tb_if.move_speed = speeds[$urandom_range(0, 7)];
      end
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
